// File: rtl/imm_gen_pkg.sv
// RV32I immediate generator shared types.
// Format codes, opcode constants, sign-extend helper.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Replicate bit msb of v into every bit above it.
  function automatic logic [31:0] sext(
    input logic [31:0] v,
    input logic [4:0]  msb
  );
    logic [31:0] r;
    r = v;
    for (int i = 0; i < 32; i++) begin
      if (i > int'(msb)) r[i] = v[msb];
    end
    return r;
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate format decode and assembly.
// Opcode port selects the format; instruction supplies bits.
module imm_decode
  import imm_gen_pkg::*;
(
  input  logic [6:0]  i_opcode,
  input  logic [31:0] i_instr,
  output logic [31:0] o_imm,
  output imm_fmt_e    o_fmt,
  output logic        o_valid
);

  logic        w_is_i;
  logic        w_is_s;
  logic        w_is_b;
  logic        w_is_u;
  logic        w_is_j;
  logic [31:0] w_raw_i;
  logic [31:0] w_raw_s;
  logic [31:0] w_raw_b;
  logic [31:0] w_raw_j;

  assign w_is_i = (i_opcode == OP_LOAD)
               || (i_opcode == OP_IMM)
               || (i_opcode == OP_JALR)
               || (i_opcode == OP_SYSTEM);
  assign w_is_s = (i_opcode == OP_STORE);
  assign w_is_b = (i_opcode == OP_BRANCH);
  assign w_is_u = (i_opcode == OP_LUI)
               || (i_opcode == OP_AUIPC);
  assign w_is_j = (i_opcode == OP_JAL);

  assign w_raw_i = {20'd0, i_instr[31:20]};
  assign w_raw_s = {20'd0, i_instr[31:25],
                    i_instr[11:7]};
  assign w_raw_b = {19'd0, i_instr[31],
                    i_instr[7],
                    i_instr[30:25],
                    i_instr[11:8], 1'b0};
  assign w_raw_j = {11'd0, i_instr[31],
                    i_instr[19:12],
                    i_instr[20],
                    i_instr[30:21], 1'b0};

  // Pick the format and assemble the extended immediate.
  always_comb begin
    o_imm   = '0;
    o_fmt   = FMT_NONE;
    o_valid = 1'b0;
    unique case (1'b1)
      w_is_i: begin
        o_imm   = sext(w_raw_i, 5'd11);
        o_fmt   = FMT_I;
        o_valid = 1'b1;
      end
      w_is_s: begin
        o_imm   = sext(w_raw_s, 5'd11);
        o_fmt   = FMT_S;
        o_valid = 1'b1;
      end
      w_is_b: begin
        o_imm   = sext(w_raw_b, 5'd12);
        o_fmt   = FMT_B;
        o_valid = 1'b1;
      end
      w_is_u: begin
        o_imm   = {i_instr[31:12], 12'd0};
        o_fmt   = FMT_U;
        o_valid = 1'b1;
      end
      w_is_j: begin
        o_imm   = sext(w_raw_j, 5'd20);
        o_fmt   = FMT_J;
        o_valid = 1'b1;
      end
      default: begin
        o_imm   = '0;
        o_fmt   = FMT_NONE;
        o_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen.sv
// RV32I immediate generator with registered outputs.
// One cycle latency, enable hold, async active-low reset.
module imm_gen
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [6:0]      opcode,
  input  logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] imm_ext,
  output logic [2:0]      imm_fmt,
  output logic            imm_valid
);

  logic [XLEN-1:0] w_imm;
  imm_fmt_e        w_fmt;
  logic            w_valid;
  logic [XLEN-1:0] r_imm;
  imm_fmt_e        r_fmt;
  logic            r_valid;

  imm_decode u_dec (
    .i_opcode (opcode),
    .i_instr  (instruction),
    .o_imm    (w_imm),
    .o_fmt    (w_fmt),
    .o_valid  (w_valid)
  );

  // Capture the decoded immediate when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_imm   <= '0;
      r_fmt   <= FMT_NONE;
      r_valid <= 1'b0;
    end else if (en) begin
      r_imm   <= w_imm;
      r_fmt   <= w_fmt;
      r_valid <= w_valid;
    end
  end

  assign imm_ext   = r_imm;
  assign imm_fmt   = r_fmt;
  assign imm_valid = r_valid;

endmodule

// File: tb/tb_imm_gen.sv
// Directed self-checking bench for imm_gen.
// Hand-computed vectors, one task per scenario.
module tb_imm_gen;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [6:0]  opcode;
  logic [31:0] instruction;
  logic [31:0] imm_ext;
  logic [2:0]  imm_fmt;
  logic        imm_valid;

  int checks;
  int failures;

  imm_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .opcode      (opcode),
    .instruction (instruction),
    .imm_ext     (imm_ext),
    .imm_fmt     (imm_fmt),
    .imm_valid   (imm_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    opcode      = 7'b0000011;
    instruction = 32'hFFFFFFFF;
    en          = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (imm_ext !== 32'h0) begin
      failures++;
      $display("FAIL reset_ext got=%h exp=%h",
               imm_ext, 32'h0);
    end
    checks++;
    if (imm_fmt !== 3'd0) begin
      failures++;
      $display("FAIL reset_fmt got=%0d exp=0",
               imm_fmt);
    end
    checks++;
    if (imm_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=0",
               imm_valid);
    end
    step();
    step();
    checks++;
    if (imm_ext !== 32'h0 || imm_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold got=%h/%b exp=0/0",
               imm_ext, imm_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_formats();
    logic [6:0]  t_op  [16];
    logic [31:0] t_ins [16];
    logic [31:0] t_ext [16];
    logic [2:0]  t_fmt [16];
    logic        t_vld [16];
    t_op[0]  = 7'h03; t_ins[0]  = 32'h80001013;
    t_ext[0] = 32'hFFFFF800; t_fmt[0] = 1;
    t_op[1]  = 7'h23; t_ins[1]  = 32'hA80314A3;
    t_ext[1] = 32'hFFFFFA89; t_fmt[1] = 2;
    t_op[2]  = 7'h63; t_ins[2]  = 32'h021182E3;
    t_ext[2] = 32'h00000824; t_fmt[2] = 3;
    t_op[3]  = 7'h37; t_ins[3]  = 32'hDEADB037;
    t_ext[3] = 32'hDEADB000; t_fmt[3] = 4;
    t_op[4]  = 7'h6F; t_ins[4]  = 32'h800000EF;
    t_ext[4] = 32'hFFF00000; t_fmt[4] = 5;
    t_op[5]  = 7'h7F; t_ins[5]  = 32'hFFFFFFFF;
    t_ext[5] = 32'h00000000; t_fmt[5] = 0;
    t_op[6]  = 7'h13; t_ins[6]  = 32'h7FF00093;
    t_ext[6] = 32'h000007FF; t_fmt[6] = 1;
    t_op[7]  = 7'h67; t_ins[7]  = 32'hFFC08067;
    t_ext[7] = 32'hFFFFFFFC; t_fmt[7] = 1;
    t_op[8]  = 7'h73; t_ins[8]  = 32'h00100073;
    t_ext[8] = 32'h00000001; t_fmt[8] = 1;
    t_op[9]  = 7'h17; t_ins[9]  = 32'h12345017;
    t_ext[9] = 32'h12345000; t_fmt[9] = 4;
    t_op[10] = 7'h13; t_ins[10] = 32'h40515093;
    t_ext[10] = 32'h00000405; t_fmt[10] = 1;
    t_op[11] = 7'h33; t_ins[11] = 32'hFFFFF033;
    t_ext[11] = 32'h00000000; t_fmt[11] = 0;
    t_op[12] = 7'h23; t_ins[12] = 32'h00000F93;
    t_ext[12] = 32'h0000001F; t_fmt[12] = 2;
    t_op[13] = 7'h63; t_ins[13] = 32'hFE000EE3;
    t_ext[13] = 32'hFFFFFFFC; t_fmt[13] = 3;
    t_op[14] = 7'h6F; t_ins[14] = 32'h7FFFF0EF;
    t_ext[14] = 32'h000FFFFE; t_fmt[14] = 5;
    t_op[15] = 7'h0F; t_ins[15] = 32'h0000000F;
    t_ext[15] = 32'h00000000; t_fmt[15] = 0;
    for (int i = 0; i < 16; i++) begin
      t_vld[i] = (t_fmt[i] != 3'd0);
    end
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      opcode      = t_op[i];
      instruction = t_ins[i];
      step();
      checks++;
      if (imm_ext !== t_ext[i]) begin
        failures++;
        $display("FAIL fmt%0d_ext got=%h exp=%h",
                 i, imm_ext, t_ext[i]);
      end
      checks++;
      if (imm_fmt !== t_fmt[i]) begin
        failures++;
        $display("FAIL fmt%0d_fmt got=%0d exp=%0d",
                 i, imm_fmt, t_fmt[i]);
      end
      checks++;
      if (imm_valid !== t_vld[i]) begin
        failures++;
        $display("FAIL fmt%0d_vld got=%b exp=%b",
                 i, imm_valid, t_vld[i]);
      end
    end
  endtask

  task automatic test_enable_zero();
    en          = 1'b1;
    opcode      = 7'h7F;
    instruction = 32'hFFFFFFFF;
    step();
    en          = 1'b0;
    opcode      = 7'h03;
    instruction = 32'h80001013;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (imm_ext !== 32'h0 || imm_fmt !== 3'd0
          || imm_valid !== 1'b0) begin
        failures++;
        $display("FAIL hold0_%0d got=%h/%0d/%b exp=0/0/0",
                 k, imm_ext, imm_fmt, imm_valid);
      end
    end
  endtask

  task automatic test_enable_hold();
    en          = 1'b1;
    opcode      = 7'h17;
    instruction = 32'h12345017;
    step();
    en          = 1'b0;
    opcode      = 7'h23;
    instruction = 32'hA80314A3;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (imm_ext !== 32'h12345000 || imm_fmt !== 3'd4
          || imm_valid !== 1'b1) begin
        failures++;
        $display("FAIL hold_%0d got=%h/%0d/%b exp=12345000/4/1",
                 k, imm_ext, imm_fmt, imm_valid);
      end
    end
    en = 1'b1;
    step();
    checks++;
    if (imm_ext !== 32'hFFFFFA89 || imm_fmt !== 3'd2) begin
      failures++;
      $display("FAIL reenable got=%h/%0d exp=fffffa89/2",
               imm_ext, imm_fmt);
    end
  endtask

  task automatic test_mid_reset();
    en          = 1'b1;
    opcode      = 7'h6F;
    instruction = 32'h800000EF;
    step();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (imm_ext !== 32'h0 || imm_fmt !== 3'd0
        || imm_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst got=%h/%0d/%b exp=0/0/0",
               imm_ext, imm_fmt, imm_valid);
    end
    opcode      = 7'h63;
    instruction = 32'h021182E3;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (imm_valid !== 1'b0) begin
      failures++;
      $display("FAIL release_pre got=%b exp=0",
               imm_valid);
    end
    step();
    checks++;
    if (imm_ext !== 32'h00000824 || imm_fmt !== 3'd3
        || imm_valid !== 1'b1) begin
      failures++;
      $display("FAIL release got=%h/%0d/%b exp=824/3/1",
               imm_ext, imm_fmt, imm_valid);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b1;
    en          = 1'b0;
    opcode      = 7'h0;
    instruction = 32'h0;
    test_reset();
    test_formats();
    test_enable_zero();
    test_enable_hold();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_gen.md
Name: imm_gen

Overview:
- Immediate generator for the RV32I single-cycle CPU datapath.
- Decodes the immediate format from a 7-bit opcode and assembles the sign-extended 32-bit immediate from the instruction word.
- Presents the immediate to the ALU operand mux, the branch target adder and the load/store address adder.
- Output is registered: one clock of latency, plus a format tag and a valid flag.

Parameters:
XLEN, 32, width of the instruction word and of the extended immediate; only 32 is supported.

Ports:
clk  input  1  system clock; rising edge active
rst_n  input  1  asynchronous active-low reset
en  input  1  output register update enable; hold the outputs when low
opcode  input  7  opcode used for format decode; always used, instruction[6:0] is ignored for decode
instruction  input  32  full instruction word; immediate bit source
imm_ext  output  32  sign-extended (U: shifted) immediate, registered
imm_fmt  output  3  registered format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J
imm_valid  output  1  registered; 1 when opcode maps to a known format

Behaviour:
- Reset: imm_ext=0, imm_fmt=NONE, imm_valid=0 while rst_n=0. Applies asynchronously on the rst_n fall and releases synchronously on the next clk edge after the rise.
- Latency: 1 cycle. Inputs sampled at the rising clk edge with en=1 appear on the outputs after that edge. With en=0 all outputs hold their values.
- Opcode → format:
  - I: 0000011 (load), 0010011 (OP-IMM), 1100111 (JALR), 1110011 (SYSTEM)
  - S: 0100011
  - B: 1100011
  - U: 0110111 (LUI), 0010111 (AUIPC)
  - J: 1101111
  - Any other opcode → NONE
- Assembly (s = instruction[31], replicated into all upper bits):
  - I: {20{s}, ins[31:20]}
  - S: {20{s}, ins[31:25], ins[11:7]}
  - B: {19{s}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}
  - U: {ins[31:12], 12'b0}
  - J: {11{s}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}
  - NONE: imm_ext=0, imm_valid=0
- OP-IMM shifts (funct3 001/101) use the plain I rule. No funct7 masking; shamt extraction is the ALU's job.
- The decode path is purely combinational: no latches, full case with default.
- X on opcode is not propagated intentionally. The default branch yields NONE/0.
- Reset asserted mid-stream clears the outputs immediately. The first update after release uses the inputs present at that edge.

Decomposition:
- Package imm_gen_pkg holds:
  - enum imm_fmt_e (NONE, I, S, B, U, J; 3-bit)
  - localparams for the nine opcodes above
  - a function sext() helper
- One combinational sub-module, imm_decode: opcode + instruction in, next imm_ext/imm_fmt/imm_valid out.
- imm_gen wraps imm_decode and adds the output register with async reset and enable.

Test Plan:
- Reset: rst_n=0 with arbitrary inputs → imm_ext=0x00000000, imm_fmt=0, imm_valid=0, immediately without a clock edge.
- I-type: opcode=0000011, instruction=0x80001013, en=1, one clock → imm_ext=0xFFFFF800, imm_fmt=1, imm_valid=1.
- S-type: opcode=0100011, instruction=0xA80314A3, one clock → imm_ext=0xFFFFFA89, imm_fmt=2.
- B-type: opcode=1100011, instruction=0x021182E3, one clock → imm_ext=0x00000824 (bit 0 zero), imm_fmt=3.
- U/J:
  - opcode=0110111, instruction=0xDEADB037 → imm_ext=0xDEADB000, imm_fmt=4.
  - opcode=1101111, instruction=0x800000EF → imm_ext=0xFFF00000, imm_fmt=5.
- Default and enable:
  - opcode=1111111, instruction=0xFFFFFFFF → imm_ext=0x00000000, imm_fmt=0, imm_valid=0.
  - Then en=0 with an I-type input → outputs unchanged over 3 clocks.
